alu_ctrl_mc: RTL

Registered, multi-cycle ALU controller for the pipelined MIPS datapath. It sits between ID/EX decode and the EX-stage ALU and multiplier. It decodes ALUOp/funct into an ALU control code plus shifter controls, and registers the result for EX. For MUL it sequences a MUL_CYCLES-long iterative multiply and exposes a ready/valid/stall handshake to the hazard unit.

---
 rtl/alu_ctrl_mc.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_mc.sv
//------------------------------------------------------------------------------
// Module      : alu_ctrl_mc
// Description : Registered ALU control decoder with iterative-MUL sequencing
//               and ready/valid/stall handshake for the EX stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_mc #(
    parameter int CTRL_W     = 4,
    parameter int OP_W       = 3,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [OP_W-1:0]   ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              shamt_sel_o,
    output logic              shift_dir_o,
    output logic              illegal_o
);

    localparam int c_CNT_W = $clog2(MUL_CYCLES + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;

    logic [3:0] w_ctrl;
    logic       w_shamt_sel;
    logic       w_shift_dir;
    logic       w_illegal;
    logic       w_mul;
    logic       w_accept;

    always_comb begin
        w_ctrl      = 4'b0000;
        w_shamt_sel = 1'b0;
        w_shift_dir = 1'b0;
        w_illegal   = 1'b0;
        w_mul       = 1'b0;
        case (ALUOp_i)
            OP_W'(3'b000): w_ctrl = 4'b0010;
            OP_W'(3'b100): w_ctrl = 4'b0010;
            OP_W'(3'b101): w_ctrl = 4'b0110;
            OP_W'(3'b110): w_ctrl = 4'b0001;
            OP_W'(3'b010): begin
                case (funct_i)
                    6'b100000: w_ctrl = 4'b0010;
                    6'b100010: w_ctrl = 4'b0110;
                    6'b100100: w_ctrl = 4'b0000;
                    6'b100101: w_ctrl = 4'b0001;
                    6'b101010: w_ctrl = 4'b0111;
                    6'b000000: begin
                        w_ctrl      = 4'b1000;
                        w_shamt_sel = 1'b1;
                    end
                    6'b000010: begin
                        w_ctrl      = 4'b1001;
                        w_shamt_sel = 1'b1;
                        w_shift_dir = 1'b1;
                    end
                    6'b000100: w_ctrl = 4'b1000;
                    6'b000110: begin
                        w_ctrl      = 4'b1001;
                        w_shift_dir = 1'b1;
                    end
                    6'b011000: begin
                        w_ctrl = 4'b1111;
                        w_mul  = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign ready_o  = (r_state == IDLE) && !(valid_o && stall_i);
    assign w_accept = valid_i && ready_o && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            ALUCtrl_o   <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            illegal_o   <= 1'b0;
            shamt_sel_o <= 1'b0;
            shift_dir_o <= 1'b0;
        end else if (flush_i) begin
            // Kill whatever is held or in flight; the control code is left as-is.
            r_state   <= IDLE;
            r_cnt     <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        ALUCtrl_o   <= CTRL_W'(w_ctrl);
                        shamt_sel_o <= w_shamt_sel;
                        shift_dir_o <= w_shift_dir;
                        illegal_o   <= w_illegal;
                        if (w_mul && (MUL_CYCLES > 1)) begin
                            valid_o <= 1'b0;
                            busy_o  <= 1'b1;
                            r_cnt   <= c_CNT_W'(MUL_CYCLES - 1);
                            r_state <= BUSY;
                        end else begin
                            valid_o <= 1'b1;
                        end
                    end else if (valid_o && !stall_i) begin
                        valid_o <= 1'b0;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
